// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO controller: opcodes, FSM encoding and data width.
package muldiv_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MUL       = 3'd1,
    DIV_SEND  = 3'd2,
    DIV_WAIT  = 3'd3,
    DIV_DRAIN = 3'd4
  } state_t;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/muldiv_mul.sv
// Operand-registered 32x32 multiplier; one shared array serves signed and unsigned products.
module muldiv_mul
  import muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                load,
  input  logic                is_signed,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] product
);

  logic [DATA_W-1:0]   a_reg, b_reg;
  logic                signed_reg;
  logic [2*DATA_W-1:0] a_ext, b_ext;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
    end else if (load) begin
      a_reg      <= a;
      b_reg      <= b;
      signed_reg <= is_signed;
    end
  end

  // Sign- or zero-extend to the full product width; the low 64 bits are then exact for both.
  assign a_ext   = {{DATA_W{signed_reg & a_reg[DATA_W-1]}}, a_reg};
  assign b_ext   = {{DATA_W{signed_reg & b_reg[DATA_W-1]}}, b_reg};
  assign product = a_ext * b_ext;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner: sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO, drives the divider AXI-stream
// handshakes and survives pipeline flushes without corrupting HI/LO.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 1  // cycles spent in MUL, legal 1..4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [DATA_W-1:0]   req_rs,
  input  logic [DATA_W-1:0]   req_rt,
  input  logic                cancel,
  output logic                done,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo,
  output logic [DATA_W-1:0]   div_dividend,
  output logic [DATA_W-1:0]   div_divisor,
  output logic                sdiv_dividend_tvalid,
  input  logic                sdiv_dividend_tready,
  output logic                sdiv_divisor_tvalid,
  input  logic                sdiv_divisor_tready,
  input  logic                sdiv_dout_tvalid,
  input  logic [2*DATA_W-1:0] sdiv_dout_tdata,
  output logic                udiv_dividend_tvalid,
  input  logic                udiv_dividend_tready,
  output logic                udiv_divisor_tvalid,
  input  logic                udiv_divisor_tready,
  input  logic                udiv_dout_tvalid,
  input  logic [2*DATA_W-1:0] udiv_dout_tdata
);

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   hi_reg, hi_next, lo_reg, lo_next;
  logic [DATA_W-1:0]   dvd_reg, dvd_next, dvs_reg, dvs_next;
  logic [2:0]          op_reg, op_next;
  logic [1:0]          cnt_reg, cnt_next;
  logic                done_reg, done_next;
  logic                drop_reg, drop_next;
  logic                dvd_valid_reg, dvd_valid_next;
  logic                dvs_valid_reg, dvs_valid_next;

  logic                accept;
  logic                sel_signed;
  logic                dvd_ready, dvs_ready, dout_valid;
  logic [2*DATA_W-1:0] dout_data;
  logic [2*DATA_W-1:0] product;

  assign accept     = req_valid & req_ready & ~cancel;
  assign sel_signed = (op_reg == OP_DIV);

  // Only the divider chosen by the latched op is listened to.
  assign dvd_ready  = sel_signed ? sdiv_dividend_tready : udiv_dividend_tready;
  assign dvs_ready  = sel_signed ? sdiv_divisor_tready  : udiv_divisor_tready;
  assign dout_valid = sel_signed ? sdiv_dout_tvalid     : udiv_dout_tvalid;
  assign dout_data  = sel_signed ? sdiv_dout_tdata      : udiv_dout_tdata;

  muldiv_mul u_mul (
    .clk       (clk),
    .resetn    (resetn),
    .load      (accept & is_mul_op(req_op)),
    .is_signed (req_op == OP_MULT),
    .a         (req_rs),
    .b         (req_rt),
    .product   (product)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      hi_reg        <= '0;
      lo_reg        <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      op_reg        <= '0;
      cnt_reg       <= '0;
      done_reg      <= 1'b0;
      drop_reg      <= 1'b0;
      dvd_valid_reg <= 1'b0;
      dvs_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      dvd_reg       <= dvd_next;
      dvs_reg       <= dvs_next;
      op_reg        <= op_next;
      cnt_reg       <= cnt_next;
      done_reg      <= done_next;
      drop_reg      <= drop_next;
      dvd_valid_reg <= dvd_valid_next;
      dvs_valid_reg <= dvs_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    dvd_next       = dvd_reg;
    dvs_next       = dvs_reg;
    op_next        = op_reg;
    cnt_next       = cnt_reg;
    done_next      = 1'b0;
    drop_next      = drop_reg;
    dvd_valid_next = dvd_valid_reg;
    dvs_valid_next = dvs_valid_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_next  = req_op;
          dvd_next = req_rs;
          dvs_next = req_rt;
          case (req_op)
            OP_MULT, OP_MULTU: begin
              state_next = MUL;
              cnt_next   = 2'(MUL_LAT - 1);
            end
            OP_DIV, OP_DIVU: begin
              state_next     = DIV_SEND;
              dvd_valid_next = 1'b1;
              dvs_valid_next = 1'b1;
            end
            OP_MTHI: begin
              hi_next   = req_rs;
              done_next = 1'b1;
            end
            OP_MTLO: begin
              lo_next   = req_rs;
              done_next = 1'b1;
            end
            default: done_next = 1'b1;
          endcase
        end
      end

      MUL: begin
        if (cancel) begin
          state_next = IDLE;
        end else if (cnt_reg == 2'd0) begin
          {hi_next, lo_next} = product;
          done_next          = 1'b1;
          state_next         = IDLE;
        end else begin
          cnt_next = cnt_reg - 2'd1;
        end
      end

      DIV_SEND: begin
        // A flush cannot withdraw tvalid; remember it and drain the result later.
        drop_next = drop_reg | cancel;
        if (dvd_valid_reg && dvd_ready) dvd_valid_next = 1'b0;
        if (dvs_valid_reg && dvs_ready) dvs_valid_next = 1'b0;
        if (!dvd_valid_next && !dvs_valid_next)
          state_next = drop_next ? DIV_DRAIN : DIV_WAIT;
      end

      DIV_WAIT: begin
        if (cancel) begin
          state_next = dout_valid ? IDLE : DIV_DRAIN;
        end else if (dout_valid) begin
          lo_next    = dout_data[2*DATA_W-1:DATA_W];
          hi_next    = dout_data[DATA_W-1:0];
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      DIV_DRAIN: begin
        if (dout_valid) begin
          drop_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign req_ready            = (state_reg == IDLE);
  assign done                 = done_reg;
  assign hi                   = hi_reg;
  assign lo                   = lo_reg;
  assign div_dividend         = dvd_reg;
  assign div_divisor          = dvs_reg;
  assign sdiv_dividend_tvalid = dvd_valid_reg &  sel_signed;
  assign sdiv_divisor_tvalid  = dvs_valid_reg &  sel_signed;
  assign udiv_dividend_tvalid = dvd_valid_reg & ~sel_signed;
  assign udiv_divisor_tvalid  = dvs_valid_reg & ~sel_signed;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with small AXI-stream divider models (index 0 signed, 1 unsigned).
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn = 1'b0;
  logic        req_valid = 1'b0, req_valid3 = 1'b0, cancel = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_rs = '0, req_rt = '0;

  logic        req_ready, done;
  logic [31:0] hi, lo, div_dividend, div_divisor;
  logic        sdiv_dividend_tvalid, sdiv_divisor_tvalid;
  logic        udiv_dividend_tvalid, udiv_divisor_tvalid;

  logic        req_ready3, done3;
  logic [31:0] hi3, lo3, dvd3, dvs3;
  logic        s_dvd_tv3, s_dvs_tv3, u_dvd_tv3, u_dvs_tv3;

  logic [1:0]  dvd_tv, dvs_tv, dvd_tr, dvs_tr, dout_tv;
  logic [63:0] dout_td [2];

  int n_vec = 0;
  int n_err = 0;

  assign dvd_tv = {udiv_dividend_tvalid, sdiv_dividend_tvalid};
  assign dvs_tv = {udiv_divisor_tvalid,  sdiv_divisor_tvalid};

  muldiv_ctrl #(.MUL_LAT(1)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .cancel(cancel), .done(done),
    .hi(hi), .lo(lo), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .sdiv_dividend_tvalid(sdiv_dividend_tvalid), .sdiv_dividend_tready(dvd_tr[0]),
    .sdiv_divisor_tvalid(sdiv_divisor_tvalid),   .sdiv_divisor_tready(dvs_tr[0]),
    .sdiv_dout_tvalid(dout_tv[0]),               .sdiv_dout_tdata(dout_td[0]),
    .udiv_dividend_tvalid(udiv_dividend_tvalid), .udiv_dividend_tready(dvd_tr[1]),
    .udiv_divisor_tvalid(udiv_divisor_tvalid),   .udiv_divisor_tready(dvs_tr[1]),
    .udiv_dout_tvalid(dout_tv[1]),               .udiv_dout_tdata(dout_td[1])
  );

  // Second instance exercises a longer multiply; its dividers are never used.
  muldiv_ctrl #(.MUL_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .cancel(cancel), .done(done3),
    .hi(hi3), .lo(lo3), .div_dividend(dvd3), .div_divisor(dvs3),
    .sdiv_dividend_tvalid(s_dvd_tv3), .sdiv_dividend_tready(1'b0),
    .sdiv_divisor_tvalid(s_dvs_tv3),  .sdiv_divisor_tready(1'b0),
    .sdiv_dout_tvalid(1'b0),          .sdiv_dout_tdata(64'd0),
    .udiv_dividend_tvalid(u_dvd_tv3), .udiv_dividend_tready(1'b0),
    .udiv_divisor_tvalid(u_dvs_tv3),  .udiv_divisor_tready(1'b0),
    .udiv_dout_tvalid(1'b0),          .udiv_dout_tdata(64'd0)
  );

  function automatic logic [63:0] div_result(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {q, r};
    end
    return {a / b, a % b};
  endfunction

  // Divider model: dividend tready after 3 valid cycles, divisor after 1, result 10 cycles later.
  for (genvar gi = 0; gi < 2; gi++) begin : g_div
    logic [2:0]  cnt_a, cnt_b;
    logic        got_a, got_b, dv;
    logic [3:0]  lat;
    logic [31:0] a_l, b_l;
    logic [63:0] dd;

    assign dvd_tr[gi]  = dvd_tv[gi] && (cnt_a >= 3'd3);
    assign dvs_tr[gi]  = dvs_tv[gi] && (cnt_b >= 3'd1);
    assign dout_tv[gi] = dv;
    assign dout_td[gi] = dd;

    always @(posedge clk) begin
      if (!resetn) begin
        cnt_a <= '0; cnt_b <= '0; got_a <= 1'b0; got_b <= 1'b0;
        lat <= '0; dv <= 1'b0; dd <= '0; a_l <= '0; b_l <= '0;
      end else begin
        dv <= 1'b0;
        if (dvd_tv[gi] && !got_a) begin
          cnt_a <= cnt_a + 3'd1;
          if (dvd_tr[gi]) begin got_a <= 1'b1; a_l <= div_dividend; end
        end
        if (dvs_tv[gi] && !got_b) begin
          cnt_b <= cnt_b + 3'd1;
          if (dvs_tr[gi]) begin got_b <= 1'b1; b_l <= div_divisor; end
        end
        if (got_a && got_b) begin
          if (lat == 4'd9) begin
            dv <= 1'b1;
            dd <= div_result(gi == 0, a_l, b_l);
            got_a <= 1'b0; got_b <= 1'b0; cnt_a <= '0; cnt_b <= '0; lat <= '0;
          end else begin
            lat <= lat + 4'd1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt, input bit to3);
    req_op = op; req_rs = rs; req_rt = rt;
    if (to3) req_valid3 = 1'b1; else req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req_valid3 = 1'b0;
  endtask

  // Follows a divide from the cycle after accept until req_ready returns, counting events.
  task automatic watch(input bit sel_s, input int cancel_cyc, input bit cancel_on_dout,
                       output int dvd_n, output int dvs_n, output int wrong_n, output int done_n,
                       output bit early_ready, output bit timed_out);
    bit seen_dout;
    bit dout_now;
    seen_dout = 1'b0; dvd_n = 0; dvs_n = 0; wrong_n = 0; done_n = 0;
    early_ready = 1'b0; timed_out = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (sel_s) begin
        dvd_n   += int'(sdiv_dividend_tvalid);
        dvs_n   += int'(sdiv_divisor_tvalid);
        wrong_n += int'(udiv_dividend_tvalid | udiv_divisor_tvalid);
      end else begin
        dvd_n   += int'(udiv_dividend_tvalid);
        dvs_n   += int'(udiv_divisor_tvalid);
        wrong_n += int'(sdiv_dividend_tvalid | sdiv_divisor_tvalid);
      end
      done_n += int'(done);
      if (req_ready) begin
        early_ready = !seen_dout;
        timed_out   = 1'b0;
        break;
      end
      dout_now = sel_s ? dout_tv[0] : dout_tv[1];
      if (dout_now) seen_dout = 1'b1;
      cancel = (k == cancel_cyc) || (cancel_on_dout && dout_now);
      tick();
      cancel = 1'b0;
    end
  endtask

  int dvd_n, dvs_n, wrong_n, done_n;
  bit early, tmo;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_ready", 64'(req_ready), 64'h1);
    chk("rst_tvalid", 64'({sdiv_dividend_tvalid, sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid}), 64'h0);
    resetn = 1'b1;
    tick();

    // MTHI / MTLO
    issue(OP_MTHI, 32'h1234_5678, 32'h0, 1'b0);
    chk("mthi_done", 64'(done), 64'h1);
    chk("mthi_hilo", {hi, lo}, {32'h1234_5678, 32'h0});
    tick();
    chk("mthi_done_pulse", 64'(done), 64'h0);
    issue(OP_MTLO, 32'hCAFE_BABE, 32'h0, 1'b0);
    chk("mtlo_done", 64'(done), 64'h1);
    chk("mtlo_hilo", {hi, lo}, {32'h1234_5678, 32'hCAFE_BABE});

    // MULT / MULTU, MUL_LAT=1
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_busy", 64'({req_ready, done}), 64'h0);
    tick();
    chk("mult_done_ready", 64'({req_ready, done}), 64'h3);
    chk("mult_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("multu_busy", 64'({req_ready, done}), 64'h0);
    tick();
    chk("multu_done_ready", 64'({req_ready, done}), 64'h3);
    chk("multu_hilo", {hi, lo}, {32'h0000_0002, 32'hFFFF_FFFA});

    // DIV -7/2 on the signed divider
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    watch(1'b1, -1, 1'b0, dvd_n, dvs_n, wrong_n, done_n, early, tmo);
    chk("div_timeout", 64'(tmo), 64'h0);
    chk("div_dvd_cycles", 64'(dvd_n), 64'd4);
    chk("div_dvs_cycles", 64'(dvs_n), 64'd2);
    chk("div_udiv_quiet", 64'(wrong_n), 64'd0);
    chk("div_done_count", 64'(done_n), 64'd1);
    chk("div_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tick();
    chk("div_done_pulse", 64'(done), 64'h0);

    // DIVU cancelled in DIV_SEND: handshakes finish, result drained
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    watch(1'b0, 0, 1'b0, dvd_n, dvs_n, wrong_n, done_n, early, tmo);
    chk("divu_cxl_timeout", 64'(tmo), 64'h0);
    chk("divu_cxl_dvd_cycles", 64'(dvd_n), 64'd4);
    chk("divu_cxl_dvs_cycles", 64'(dvs_n), 64'd2);
    chk("divu_cxl_sdiv_quiet", 64'(wrong_n), 64'd0);
    chk("divu_cxl_done_count", 64'(done_n), 64'd0);
    chk("divu_cxl_early_ready", 64'(early), 64'h0);
    chk("divu_cxl_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // DIV with cancel coincident with dout_tvalid in DIV_WAIT
    issue(OP_DIV, 32'd20, 32'd3, 1'b0);
    watch(1'b1, -1, 1'b1, dvd_n, dvs_n, wrong_n, done_n, early, tmo);
    chk("div_cxl_timeout", 64'(tmo), 64'h0);
    chk("div_cxl_done_count", 64'(done_n), 64'd0);
    chk("div_cxl_early_ready", 64'(early), 64'h0);
    chk("div_cxl_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // DIVU 100/7 uncancelled
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    watch(1'b0, -1, 1'b0, dvd_n, dvs_n, wrong_n, done_n, early, tmo);
    chk("divu_timeout", 64'(tmo), 64'h0);
    chk("divu_sdiv_quiet", 64'(wrong_n), 64'd0);
    chk("divu_done_count", 64'(done_n), 64'd1);
    chk("divu_hilo", {hi, lo}, {32'h0000_0002, 32'h0000_000E});

    // MULT cancelled in its final (only) cycle
    issue(OP_MULT, 32'd5, 32'd5, 1'b0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("mult_cxl_ready_done", 64'({req_ready, done}), 64'h2);
    chk("mult_cxl_hilo", {hi, lo}, {32'h0000_0002, 32'h0000_000E});

    // req_valid during cancel in IDLE is never accepted
    req_op = OP_MTHI; req_rs = 32'h0000_DEAD; req_valid = 1'b1; cancel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_cxl_done", 64'(done), 64'h0);
    end
    req_valid = 1'b0; cancel = 1'b0;
    tick();
    chk("idle_cxl_done_after", 64'(done), 64'h0);
    chk("idle_cxl_hi", 64'(hi), 64'h2);

    // MUL_LAT=3: full multiply, then one cancelled in its 2nd cycle
    issue(OP_MULT, 32'd7, 32'hFFFF_FFFB, 1'b1);
    chk("mul3_busy0", 64'({req_ready3, done3}), 64'h0);
    tick(); tick();
    chk("mul3_busy2", 64'({req_ready3, done3}), 64'h0);
    tick();
    chk("mul3_done_ready", 64'({req_ready3, done3}), 64'h3);
    chk("mul3_hilo", {hi3, lo3}, {32'hFFFF_FFFF, 32'hFFFF_FFDD});
    issue(OP_MULT, 32'd3, 32'd3, 1'b1);
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("mul3_cxl_ready_done", 64'({req_ready3, done3}), 64'h2);
    tick(); tick();
    chk("mul3_cxl_done_late", 64'(done3), 64'h0);
    chk("mul3_cxl_hilo", {hi3, lo3}, {32'hFFFF_FFFF, 32'hFFFF_FFDD});

    // Reset asserted while waiting on the divider
    issue(OP_DIV, 32'd50, 32'd5, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk("rst_mid_busy", 64'(req_ready), 64'h0);
    resetn = 1'b0;
    tick();
    chk("rst_mid_hilo", {hi, lo}, 64'h0);
    chk("rst_mid_ready_done", 64'({req_ready, done}), 64'h2);
    chk("rst_mid_latches", {div_dividend, div_divisor}, 64'h0);
    chk("rst_mid_tvalid", 64'({sdiv_dividend_tvalid, sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid}), 64'h0);
    resetn = 1'b1;
    done_n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      done_n += int'(done);
    end
    chk("rst_mid_quiet_after", 64'(done_n), 64'd0);
    chk("rst_mid_hilo_after", {hi, lo}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Owns the architectural HI/LO registers and sequences all HI/LO-writing operations: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Sits beside the EXE stage. Accepts one request at a time, drives the AXI-stream handshakes of the external signed and unsigned divider IPs, runs a parameterised multi-cycle multiply, and exposes hi/lo for MFHI/MFLO.
- An exception/ERET flush (cancel) kills an in-flight operation without corrupting HI/LO, including draining a divider that cannot be aborted.

Parameters:
MUL_LAT, 1, cycles spent in MUL state before HI/LO write; legal 1..4.

Ports:
clk  in  1  clock
resetn  in  1  reset
req_valid  in  1  EXE presents an operation
req_ready  out  1  controller can accept; high only in IDLE
req_op  in  3  operation code (package constants)
req_rs  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
req_rt  in  32  rt operand (divisor / multiplier)
cancel  in  1  pipeline flush (WS exception or ERET); level, sampled every cycle
done  out  1  one-cycle pulse: hi/lo now hold the result of the last accepted op
hi  out  32  HI register
lo  out  32  LO register
div_dividend  out  32  latched rs, shared tdata to both dividers
div_divisor  out  32  latched rt, shared tdata to both dividers
sdiv_dividend_tvalid  out  1  signed divider dividend valid
sdiv_dividend_tready  in  1  signed divider dividend ready
sdiv_divisor_tvalid  out  1  signed divider divisor valid
sdiv_divisor_tready  in  1  signed divider divisor ready
sdiv_dout_tvalid  in  1  signed result valid
sdiv_dout_tdata  in  64  {quotient, remainder}
udiv_dividend_tvalid, udiv_dividend_tready, udiv_divisor_tvalid, udiv_divisor_tready, udiv_dout_tvalid, udiv_dout_tdata: same directions and widths as the sdiv_* ports, for the unsigned divider.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low (resetn).
- Reset values: state=IDLE, hi=0, lo=0, done=0, all tvalid=0, operand latches=0, drop=0.
- Accept: accept = req_valid & req_ready & ~cancel. On accept, latch req_rs/req_rt/req_op. req_valid while cancel=1 is never accepted.
- States: IDLE, MUL, DIV_SEND, DIV_WAIT, DIV_DRAIN.
- IDLE, accept MTHI/MTLO: write hi (or lo) = req_rs at that edge; done=1 next cycle; stay IDLE.
- IDLE, accept reserved op (6,7): no write; done=1 next cycle; stay IDLE.
- IDLE, accept MULT/MULTU -> MUL, counter=MUL_LAT-1.
  - In MUL, product is 64-bit: signed for MULT, zero-extended for MULTU.
  - When counter=0: {hi,lo}=product, done=1 with new values, -> IDLE.
  - cancel in MUL: -> IDLE, no write, no done.
- IDLE, accept DIV/DIVU -> DIV_SEND; assert dividend and divisor tvalid of the selected divider only.
- DIV_SEND:
  - Each tvalid drops independently the cycle after its tready&tvalid handshake; tdata is stable throughout.
  - When both handshakes are complete -> DIV_WAIT, or DIV_DRAIN if drop is set.
  - cancel in DIV_SEND sets drop. Handshakes must still complete; tvalid is never withdrawn.
- DIV_WAIT:
  - On dout_tvalid of the selected divider: lo=tdata[63:32] (quotient), hi=tdata[31:0] (remainder), done=1, -> IDLE.
  - cancel in DIV_WAIT -> DIV_DRAIN.
- DIV_DRAIN: wait for dout_tvalid; discard the result; no done; -> IDLE; clear drop.
- Simultaneous events:
  - cancel in the same cycle as dout_tvalid in DIV_WAIT: result discarded, -> IDLE.
  - cancel in the same cycle as the final MUL cycle: no write.
- The unselected divider's dout_tvalid is ignored in every state.
- req_ready = (state==IDLE). The next op may be accepted in the same cycle done is high.
- Divide by zero: the divider output is written as-is; no trap.
- resetn low mid-operation returns to reset values. The divider IPs are reset externally by the same signal.

Decomposition:
- Shared package muldiv_pkg: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5; state encoding; DATA_W=32.
- One sub-module, muldiv_mul: an operand-registered 32x32 signed/unsigned multiplier producing a 64-bit result. The controller only sequences it.

Test Plan:
- Reset, then MTHI rs=0x12345678 -> done 1 cycle later; hi=0x12345678, lo=0. Then MTLO rs=0xCAFEBABE -> lo=0xCAFEBABE, hi unchanged.
- MULT rs=0xFFFFFFFE (-2), rt=3, MUL_LAT=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA. req_ready low for exactly 1 cycle.
- DIV rs=-7, rt=2 with a divider model (tready delayed 3 cycles, latency 10) -> only sdiv tvalids assert, each held until its handshake; lo=0xFFFFFFFD, hi=0xFFFFFFFF; single done pulse.
- DIVU rs=100, rt=7; cancel asserted during DIV_SEND -> handshakes still complete, result discarded, hi/lo unchanged, no done; req_ready returns only after udiv_dout_tvalid.
- DIV in DIV_WAIT with cancel coincident with sdiv_dout_tvalid -> hi/lo unchanged, no done. MULT with MUL_LAT=3 cancelled in its 2nd cycle -> no write.
- req_valid held with cancel=1 in IDLE -> not accepted. resetn low during DIV_WAIT -> all outputs return to reset values next cycle.
